// File: rtl/inst_fetch_queue.sv
// Fetch-side queue: issues sequential fetch requests under a credit limit, buffers
// in-order responses and presents {instr, pc} to decode; redirects flush and discard.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD,
    input  logic        stallD
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   expect_pc_q, expect_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          started_q;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [CW+1:0] inflight_s;
    logic          credit_s;
    logic          accept_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          nonempty_s;
    logic [CW-1:0] redir_sum_s;
    logic [CW-1:0] redir_discard_s;

    // Entries, live requests and to-be-dropped requests all share the DEPTH credit pool,
    // which is what guarantees a push always finds a free slot.
    assign inflight_s = {2'b00, count_q} + {2'b00, outstanding_q} + {2'b00, discard_q};
    assign credit_s   = (inflight_s < (CW+2)'(DEPTH));
    assign nonempty_s = (count_q != {CW{1'b0}});

    // started_q holds req_valid low until the first clock edge after reset release
    assign req_valid  = started_q & ~redirect & credit_s;
    assign req_addr   = fetch_pc_q;
    assign accept_s   = req_valid & req_ready;

    assign validD     = nonempty_s & ~redirect;
    assign pop_s      = validD & ~stallD;
    assign instrD     = nonempty_s ? instr_mem_q[head_q] : 32'h0000_0000;
    assign pcD        = nonempty_s ? pc_mem_q[head_q]    : 32'h0000_0000;

    assign drop_s     = resp_valid & (discard_q != {CW{1'b0}});
    assign push_s     = resp_valid & ~drop_s & (outstanding_q != {CW{1'b0}}) & ~redirect;
    assign redir_sum_s = discard_q + outstanding_q;

    // Discard count after a redirect; a response landing in the redirect cycle is consumed
    always_comb begin
        redir_discard_s = redir_sum_s;
        if (resp_valid && (redir_sum_s != {CW{1'b0}})) begin
            redir_discard_s = redir_sum_s - CW'(1'b1);
        end else begin
            redir_discard_s = redir_sum_s;
        end
    end

    // Next-state logic: redirect overrides request accept, response push and pop
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        expect_pc_d   = expect_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        head_d        = head_q;
        tail_d        = tail_q;
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            expect_pc_d   = redirect_pc;
            count_d       = {CW{1'b0}};
            head_d        = tail_q;
            tail_d        = tail_q;
            outstanding_d = {CW{1'b0}};
            discard_d     = redir_discard_s;
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                tail_d      = tail_q + PW'(1'b1);
                expect_pc_d = expect_pc_q + 32'd4;
            end else begin
                tail_d      = tail_q;
                expect_pc_d = expect_pc_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1'b1);
            end else begin
                head_d = head_q;
            end
            outstanding_d = outstanding_q + CW'(accept_s) - CW'(push_s);
            discard_d     = discard_q - CW'(drop_s);
            count_d       = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            expect_pc_q   <= RESET_PC;
            count_q       <= {CW{1'b0}};
            outstanding_q <= {CW{1'b0}};
            discard_q     <= {CW{1'b0}};
            head_q        <= {PW{1'b0}};
            tail_q        <= {PW{1'b0}};
            started_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            expect_pc_q   <= expect_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            started_q     <= 1'b1;
        end
    end

    // Queue storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_q[tail_q] <= resp_instr;
            pc_mem_q[tail_q]    <= expect_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_inst_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instrD, pcD;
    logic        validD, stallD;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_instr(resp_instr),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instrD(instrD), .pcD(pcD), .validD(validD), .stallD(stallD)
    );

    int checks = 0;
    int errors = 0;

    // reference model: live request addresses, drop count, delivered queue
    bit          started;
    logic [31:0] m_fetch;
    int          m_disc;
    logic [31:0] m_out[$];
    logic [63:0] m_fifo[$];
    // memory side: addresses the DUT actually requested, answered in order
    logic [31:0] mem_q[$];

    bit          obs_rv, obs_vd;
    logic [31:0] obs_pc, obs_instr, obs_addr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3c1d_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        started = 1'b0;
        m_fetch = RPC;
        m_disc  = 0;
        m_out.delete();
        m_fifo.delete();
        mem_q.delete();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rv_held_after_release", {31'h0, req_valid}, 32'h0);
        @(posedge clk);
        started = 1'b1;
    endtask

    task automatic step(input bit rr, input bit rv, input bit rd, input logic [31:0] rpc,
                        input bit sd, input bit ri_en, input logic [31:0] ri);
        logic [63:0] e;
        logic [31:0] a;
        bit          exp_rv, exp_vd, acc_dut, pop, acc;
        int          n;
        @(negedge clk);
        req_ready   = rr;
        resp_valid  = rv && (mem_q.size() > 0);
        resp_instr  = resp_valid ? (ri_en ? ri : word_of(mem_q[0])) : 32'h0;
        redirect    = rd;
        redirect_pc = rpc;
        stallD      = sd;
        #1;
        assert (!(resp_valid && m_out.size() == 0 && m_disc == 0))
            else $error("protocol: response with nothing outstanding");
        exp_rv = started && !rd && ((m_fifo.size() + m_out.size() + m_disc) < DEPTH);
        exp_vd = (m_fifo.size() != 0) && !rd;
        e      = (m_fifo.size() != 0) ? m_fifo[0] : 64'h0;
        chk("req_valid", {31'h0, req_valid}, {31'h0, exp_rv});
        chk("req_addr", req_addr, m_fetch);
        chk("validD", {31'h0, validD}, {31'h0, exp_vd});
        chk("instrD", instrD, e[63:32]);
        chk("pcD", pcD, e[31:0]);
        obs_rv = req_valid; obs_vd = validD; obs_pc = pcD; obs_instr = instrD; obs_addr = req_addr;
        acc_dut = req_valid && req_ready;
        a       = req_addr;
        acc     = exp_rv && rr;
        pop     = exp_vd && !sd;
        @(posedge clk);
        if (resp_valid) void'(mem_q.pop_front());
        if (acc_dut) mem_q.push_back(a);
        if (rd) begin
            n = m_disc + m_out.size();
            if (resp_valid && n > 0) n--;
            m_disc = n;
            m_out.delete();
            m_fifo.delete();
            m_fetch = rpc;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (resp_valid) begin
                if (m_disc > 0) m_disc--;
                else if (m_out.size() > 0) m_fifo.push_back({resp_instr, m_out.pop_front()});
            end
            if (acc) begin
                m_out.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (mem_q.size() == 0 && m_fifo.size() == 0 && m_disc == 0) break;
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    // redirect to base, then stream and expect need back-to-back deliveries from base
    task automatic run_stream(input logic [31:0] base, input int need);
        int n, first, last;
        n = 0; first = 0; last = 0;
        drain();
        step(1'b1, 1'b1, 1'b1, base, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 60 && n < need; c++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (obs_vd) begin
                chk("stream_pc", obs_pc, base + 32'(4 * n));
                if (n == 0) first = c;
                last = c;
                n++;
            end
        end
        chk("stream_count", 32'(n), 32'(need));
        chk("stream_no_bubble", 32'(last - first), 32'(need - 1));
    endtask

    initial begin
        bit          seen;
        logic [31:0] rpc;
        rst = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_instr = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; stallD = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("rst_validD", {31'h0, validD}, 32'h0);
        chk("rst_instrD", instrD, 32'h0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_req_addr", req_addr, RPC);
        release_rst();

        // 1: first fetch and first two instructions
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t1_first_addr", obs_addr, 32'hbfc00000);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h24010001);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h24020002);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t1_pc0", obs_pc, 32'hbfc00000);
        chk("t1_instr0", obs_instr, 32'h24010001);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t1_pc1", obs_pc, 32'hbfc00004);
        chk("t1_instr1", obs_instr, 32'h24020002);

        // 2: full-throughput streaming
        run_stream(32'h0000_1000, 16);

        // 3: backpressure fills the credit pool, then release
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t3_rv_low", {31'h0, obs_rv}, 32'h0);
        chk("t3_vd_full", {31'h0, obs_vd}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (obs_rv) seen = 1'b1;
        end
        chk("t3_rv_back", {31'h0, seen}, 32'h1);
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // 4: redirect with three requests outstanding
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t4_outstanding", 32'(mem_q.size()), 32'd3);
        step(1'b0, 1'b0, 1'b1, 32'hbfc00380, 1'b0, 1'b0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (obs_vd) begin
                seen = 1'b1;
                chk("t4_pc", obs_pc, 32'hbfc00380);
                chk("t4_instr", obs_instr, word_of(32'hbfc00380));
            end
        end
        chk("t4_seen", {31'h0, seen}, 32'h1);

        // 5: redirect coinciding with a response, two outstanding
        drain();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t5_outstanding", 32'(mem_q.size()), 32'd2);
        step(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (obs_vd) begin
                seen = 1'b1;
                chk("t5_pc", obs_pc, 32'h0000_2000);
                chk("t5_instr", obs_instr, word_of(32'h0000_2000));
            end
        end
        chk("t5_seen", {31'h0, seen}, 32'h1);

        // fetch address wraps through zero
        run_stream(32'hffff_fff8, 6);

        // random traffic with occasional redirects, some near the top of the address space
        for (int i = 0; i < 400; i++) begin
            rpc = ($urandom_range(0, 2) == 0) ? (32'hffff_fff0 | (32'($urandom_range(0, 3)) << 2))
                                              : ($urandom() & 32'hffff_fffc);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0), rpc, 1'($urandom_range(0, 2) == 0),
                 1'b0, 32'h0);
        end

        // 6: asynchronous reset with three entries queued
        drain();
        for (int i = 0; i < 20; i++) begin
            if (m_fifo.size() == 3) break;
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        @(negedge clk);
        req_ready = 1'b0; resp_valid = 1'b0; redirect = 1'b0; stallD = 1'b1;
        #1;
        chk("t6_vd_pre", {31'h0, validD}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_vd_rst", {31'h0, validD}, 32'h0);
        chk("t6_rv_rst", {31'h0, req_valid}, 32'h0);
        chk("t6_pc_rst", pcD, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        release_rst();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t6_restart_rv", {31'h0, obs_rv}, 32'h1);
        chk("t6_restart_addr", obs_addr, RPC);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
